prime_gen: RTL and testbench



---
 rtl/prime_gen.sv | 96 +++++++++
 tb/tb_prime_gen.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prime_gen.sv
// prime_gen: streams every prime that fits in WIDTH bits, in ascending order,
// testing each candidate by trial division done as repeated subtraction.
module prime_gen #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic             busy,
    output logic             done
);
    typedef enum logic [1:0] {IDLE, TEST, EMIT, DONE} state_t;

    localparam logic [WIDTH-1:0] MAX = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] TWO = WIDTH'(2);

    state_t             r_state;
    logic [WIDTH-1:0]   r_cand;
    logic [WIDTH-1:0]   r_d;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_out;

    logic [2*WIDTH-1:0] w_dSquared;
    logic               w_isPrime;
    logic               w_atMax;
    logic [WIDTH-1:0]   w_nextCand;

    // Square at double width so the comparison can never overflow
    assign w_dSquared = {{WIDTH{1'b0}}, r_d} * {{WIDTH{1'b0}}, r_d};
    assign w_isPrime  = w_dSquared > {{WIDTH{1'b0}}, r_cand};
    assign w_atMax    = (r_cand == MAX);
    assign w_nextCand = r_cand + WIDTH'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cand  <= '0;
            r_d     <= '0;
            r_rem   <= '0;
            r_out   <= '0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_state <= TEST;
                        r_cand  <= TWO;
                        r_d     <= TWO;
                        r_rem   <= TWO;
                    end
                end
                TEST: begin
                    if (w_isPrime) begin
                        r_out   <= r_cand;
                        r_state <= EMIT;
                    end else if (r_rem >= r_d) begin
                        r_rem <= r_rem - r_d;
                    end else if (r_rem == '0) begin
                        if (w_atMax) begin
                            r_state <= DONE;
                        end else begin
                            r_cand <= w_nextCand;
                            r_d    <= TWO;
                            r_rem  <= w_nextCand;
                        end
                    end else begin
                        r_d   <= r_d + WIDTH'(1);
                        r_rem <= r_cand;
                    end
                end
                EMIT: begin
                    // The MAX check keeps cand from ever wrapping back to zero
                    if (out_ready) begin
                        if (w_atMax) begin
                            r_state <= DONE;
                        end else begin
                            r_state <= TEST;
                            r_cand  <= w_nextCand;
                            r_d     <= TWO;
                            r_rem   <= w_nextCand;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign out       = r_out;
    assign out_valid = (r_state == EMIT);
    assign busy      = (r_state == TEST) || (r_state == EMIT);
    assign done      = (r_state == DONE);

endmodule

// File: tb/tb_prime_gen.sv
// tb_prime_gen: drives three prime_gen instances (WIDTH 8, 4, 5) and checks
// the prime stream, its timing and the control flags against a reference model.
module tb_prime_gen;

    logic        clk;
    logic        rst_n;
    logic [2:0]  startV;
    logic [2:0]  readyV;
    logic [2:0]  validV;
    logic [2:0]  busyV;
    logic [2:0]  doneV;
    logic [7:0]  out8;
    logic [3:0]  out4;
    logic [4:0]  out5;

    logic [1:0]  sel;
    logic [15:0] vOut;
    logic        vValid;
    logic        vBusy;
    logic        vDone;

    int checkCount = 0;
    int passCount  = 0;

    prime_gen #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(startV[0]), .out_ready(readyV[0]),
        .out(out8), .out_valid(validV[0]), .busy(busyV[0]), .done(doneV[0])
    );

    prime_gen #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(startV[1]), .out_ready(readyV[1]),
        .out(out4), .out_valid(validV[1]), .busy(busyV[1]), .done(doneV[1])
    );

    prime_gen #(.WIDTH(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .start(startV[2]), .out_ready(readyV[2]),
        .out(out5), .out_valid(validV[2]), .busy(busyV[2]), .done(doneV[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One view onto whichever instance the current test is exercising
    always_comb begin
        vOut = '0;
        case (sel)
            2'd0:    vOut = {8'd0, out8};
            2'd1:    vOut = {12'd0, out4};
            default: vOut = {11'd0, out5};
        endcase
    end
    assign vValid = validV[sel];
    assign vBusy  = busyV[sel];
    assign vDone  = doneV[sel];

    function automatic bit isPrime(input int n);
        if (n < 2) return 0;
        for (int k = 2; k < n; k++)
            if (n % k == 0) return 0;
        return 1;
    endfunction

    // Cycles spent testing c: floor(c/d)+1 per divisor tried, +1 to detect a prime
    function automatic int costOf(input int c);
        int total;
        total = 0;
        for (int d = 2; d * d <= c; d++) begin
            total += c / d + 1;
            if (c % d == 0) return total;
        end
        return total + 1;
    endfunction

    function automatic int costRange(input int lo, input int hi);
        int total;
        total = 0;
        for (int c = lo + 1; c <= hi; c++) total += costOf(c);
        return total;
    endfunction

    task automatic doReset();
        startV = '0;
        readyV = '0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic pulseStart();
        @(negedge clk);
        startV[sel] = 1'b1;
        @(negedge clk);
        startV[sel] = 1'b0;
    endtask

    task automatic waitForValid(output int gap, output bit ok);
        gap = 0;
        ok  = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            if (vValid) begin
                ok = 1'b1;
                return;
            end
            gap++;
            @(negedge clk);
        end
    endtask

    task automatic acceptOne();
        readyV[sel] = 1'b1;
        @(negedge clk);
        readyV[sel] = 1'b0;
    endtask

    // Full run from start to done, checking every prime, every gap and the final done
    task automatic runSequence(input int w, input bit randomReady);
        int  expPrimes[$];
        int  maxv, idx, prev, gap, cyc, want;
        bit  pending, seen, finished;
        maxv = (1 << w) - 1;
        for (int n = 2; n <= maxv; n++)
            if (isPrime(n)) expPrimes.push_back(n);
        pulseStart();
        idx = 0; prev = 1; gap = 0; cyc = 0;
        seen = 1'b0; finished = 1'b0; pending = 1'b0;
        while (!finished && cyc < 70000) begin
            if (vDone) begin
                finished = 1'b1;
                checkCount++;
                if (idx != expPrimes.size() || gap != costRange(prev, maxv) || vValid)
                    $display("[TB] FAIL doneArrival w=%0d: got count=%0d gap=%0d valid=%0b, expected count=%0d gap=%0d valid=0",
                             w, idx, gap, vValid, expPrimes.size(), costRange(prev, maxv));
                else passCount++;
            end else if (vValid) begin
                want = (idx < expPrimes.size()) ? expPrimes[idx] : -1;
                if (!seen) begin
                    seen = 1'b1;
                    checkCount++;
                    if (int'(vOut) !== want)
                        $display("[TB] FAIL primeValue w=%0d idx=%0d: got %0d expected %0d", w, idx, vOut, want);
                    else passCount++;
                    checkCount++;
                    if (gap !== costRange(prev, want))
                        $display("[TB] FAIL primeGap w=%0d prime=%0d: got %0d cycles expected %0d", w, want, gap, costRange(prev, want));
                    else passCount++;
                end else begin
                    checkCount++;
                    if (int'(vOut) !== want || !vBusy)
                        $display("[TB] FAIL heldPrime w=%0d: got out=%0d busy=%0b expected out=%0d busy=1", w, vOut, vBusy, want);
                    else passCount++;
                end
                readyV[sel] = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
                pending = readyV[sel];
            end else begin
                gap++;
                readyV[sel] = 1'($urandom_range(0, 1));
                pending = 1'b0;
            end
            @(negedge clk);
            cyc++;
            if (pending) begin
                prev = want;
                idx++;
                gap = 0;
                seen = 1'b0;
                pending = 1'b0;
            end
        end
        if (!finished) begin
            checkCount++;
            $display("[TB] FAIL sequenceTimeout w=%0d: got no done after %0d cycles, expected done", w, cyc);
        end
        readyV[sel] = 1'b1;
        repeat (5) begin
            @(negedge clk);
            checkCount++;
            if (!vDone || vValid || vBusy)
                $display("[TB] FAIL doneHold w=%0d: got done=%0b valid=%0b busy=%0b expected 1/0/0", w, vDone, vValid, vBusy);
            else passCount++;
        end
        readyV[sel] = 1'b0;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        startV = '0;
        readyV = '0;
        for (int s = 0; s < 3; s++) begin
            sel = 2'(s);
            #1;
            checkCount++;
            if ({vValid, vBusy, vDone, vOut} !== 19'd0)
                $display("[TB] FAIL resetState inst=%0d: got valid=%0b busy=%0b done=%0b out=%0d expected all 0",
                         s, vValid, vBusy, vDone, vOut);
            else passCount++;
        end
        sel = 2'd0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checkCount++;
        if ({vValid, vBusy, vDone, vOut} !== 19'd0)
            $display("[TB] FAIL idleNoStart: got valid=%0b busy=%0b done=%0b out=%0d expected all 0", vValid, vBusy, vDone, vOut);
        else passCount++;
    endtask

    task automatic test_backpressure();
        int gap;
        bit ok;
        sel = 2'd0;
        doReset();
        pulseStart();
        waitForValid(gap, ok);
        checkCount++;
        if (!ok || vOut !== 16'd2 || gap !== 1)
            $display("[TB] FAIL firstPrime: got ok=%0b out=%0d gap=%0d expected ok=1 out=2 gap=1", ok, vOut, gap);
        else passCount++;
        repeat (10) begin
            @(negedge clk);
            checkCount++;
            if (!vValid || vOut !== 16'd2 || !vBusy)
                $display("[TB] FAIL stall: got valid=%0b out=%0d busy=%0b expected 1/2/1", vValid, vOut, vBusy);
            else passCount++;
        end
        acceptOne();
        checkCount++;
        if (vValid || !vBusy)
            $display("[TB] FAIL validDrop: got valid=%0b busy=%0b expected 0/1", vValid, vBusy);
        else passCount++;
        waitForValid(gap, ok);
        checkCount++;
        if (!ok || vOut !== 16'd3 || gap !== 1)
            $display("[TB] FAIL afterStall: got ok=%0b out=%0d gap=%0d expected ok=1 out=3 gap=1", ok, vOut, gap);
        else passCount++;
    endtask

    task automatic test_start_during_busy();
        int gap;
        bit ok;
        int seq[4] = '{2, 3, 5, 7};
        sel = 2'd0;
        doReset();
        pulseStart();
        foreach (seq[i]) begin
            waitForValid(gap, ok);
            checkCount++;
            if (!ok || int'(vOut) !== seq[i])
                $display("[TB] FAIL busyWalk: got ok=%0b out=%0d expected %0d", ok, vOut, seq[i]);
            else passCount++;
            acceptOne();
        end
        // Candidate 8 takes five TEST cycles, so cycle 8 lands inside candidate 9
        repeat (7) @(negedge clk);
        startV[sel] = 1'b1;
        @(negedge clk);
        startV[sel] = 1'b0;
        waitForValid(gap, ok);
        checkCount++;
        if (!ok || vOut !== 16'd11 || gap + 8 !== costRange(7, 11))
            $display("[TB] FAIL startIgnored: got ok=%0b out=%0d gap=%0d expected out=11 gap=%0d",
                     ok, vOut, gap + 8, costRange(7, 11));
        else passCount++;
    endtask

    task automatic test_async_reset();
        int gap;
        bit ok;
        int seq[4] = '{2, 3, 5, 7};
        sel = 2'd0;
        doReset();
        pulseStart();
        foreach (seq[i]) begin
            waitForValid(gap, ok);
            checkCount++;
            if (!ok || int'(vOut) !== seq[i])
                $display("[TB] FAIL resetWalk: got ok=%0b out=%0d expected %0d", ok, vOut, seq[i]);
            else passCount++;
            if (i < 3) acceptOne();
        end
        #2;
        rst_n = 1'b0;
        #1;
        checkCount++;
        if ({vValid, vBusy, vDone, vOut} !== 19'd0)
            $display("[TB] FAIL asyncReset: got valid=%0b busy=%0b done=%0b out=%0d expected all 0", vValid, vBusy, vDone, vOut);
        else passCount++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            checkCount++;
            if ({vValid, vBusy, vDone, vOut} !== 19'd0)
                $display("[TB] FAIL postResetIdle: got valid=%0b busy=%0b done=%0b out=%0d expected all 0", vValid, vBusy, vDone, vOut);
            else passCount++;
        end
        pulseStart();
        waitForValid(gap, ok);
        checkCount++;
        if (!ok || vOut !== 16'd2 || gap !== 1)
            $display("[TB] FAIL restartAfterReset: got ok=%0b out=%0d gap=%0d expected out=2 gap=1", ok, vOut, gap);
        else passCount++;
    endtask

    task automatic test_width4_restart();
        int gap;
        bit ok;
        sel = 2'd1;
        doReset();
        runSequence(4, 1'b1);
        pulseStart();
        waitForValid(gap, ok);
        checkCount++;
        if (!ok || vOut !== 16'd2 || gap !== 1 || vDone)
            $display("[TB] FAIL restartAfterDone: got ok=%0b out=%0d gap=%0d done=%0b expected out=2 gap=1 done=0",
                     ok, vOut, gap, vDone);
        else passCount++;
    endtask

    task automatic test_width5_back_to_back();
        sel = 2'd2;
        doReset();
        runSequence(5, 1'b0);
    endtask

    task automatic test_width8_random();
        sel = 2'd0;
        doReset();
        runSequence(8, 1'b1);
    endtask

    initial begin
        sel = 2'd0;
        test_reset();
        test_backpressure();
        test_start_during_busy();
        test_async_reset();
        test_width4_restart();
        test_width5_back_to_back();
        test_width8_random();
        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
